// File: rtl/keypad_entry_sequencer.sv
// Keypad entry sequencer: buffers six digits and replays them to a lock controller
// as three digit-pair strobes followed by a judge strobe.
module keypad_entry_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] inA,
  output logic [3:0] inB,
  output logic       a0,
  output logic       a1,
  output logic       load_stb,
  output logic [2:0] digit_count,
  output logic       busy,
  output logic       entry_err,
  output logic       timeout
);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    EMIT0   = 3'd1,
    EMIT1   = 3'd2,
    EMIT2   = 3'd3,
    JUDGE   = 3'd4
  } state_t;

  localparam logic [3:0] KEY_BACK  = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  state_t      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [23:0] timer_q, timer_d;
  logic [3:0]  slot_q [6];
  logic [3:0]  slot_d [6];
  logic [3:0]  inA_q, inA_d;
  logic [3:0]  inB_q, inB_d;
  logic [1:0]  stage_q, stage_d;
  logic        load_q, load_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        to_q, to_d;
  logic        timeoutHit;

  // Timeout only fires on a quiet cycle with a partial entry; any key wins the tie.
  assign timeoutHit = (state_q == COLLECT) && !key_valid && (count_q != 3'd0) &&
                      (timer_q == TIMEOUT_CYCLES - 24'd1);

  // Outputs are computed for the state being entered, so they appear registered
  // in the same cycle the FSM occupies that state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slot_d  = slot_q;
    inA_d   = inA_q;
    inB_d   = inB_q;
    stage_d = stage_q;
    load_d  = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;

    case (state_q)
      COLLECT: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (count_q < 3'd6) begin
              slot_d[count_q] = key_code;
              count_d         = count_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_BACK) begin
            if (count_q != 3'd0) count_d = count_q - 3'd1;
            else                 err_d   = 1'b1;
          end else if (key_code == KEY_ENTER) begin
            if (count_q == 3'd6) begin
              state_d = EMIT0;
              stage_d = 2'b00;
              inA_d   = slot_q[0];
              inB_d   = slot_q[1];
              load_d  = 1'b1;
              busy_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_CLEAR) begin
            count_d = 3'd0;
          end
        end else if (timeoutHit) begin
          count_d = 3'd0;
          to_d    = 1'b1;
        end
      end
      EMIT0: begin
        state_d = EMIT1;
        stage_d = 2'b01;
        inA_d   = slot_q[2];
        inB_d   = slot_q[3];
        load_d  = 1'b1;
        busy_d  = 1'b1;
      end
      EMIT1: begin
        state_d = EMIT2;
        stage_d = 2'b10;
        inA_d   = slot_q[4];
        inB_d   = slot_q[5];
        load_d  = 1'b1;
        busy_d  = 1'b1;
      end
      EMIT2: begin
        state_d = JUDGE;
        stage_d = 2'b11;
        inA_d   = 4'd0;
        inB_d   = 4'd0;
        load_d  = 1'b1;
        busy_d  = 1'b1;
      end
      JUDGE: begin
        state_d = COLLECT;
        count_d = 3'd0;
      end
      default: begin
        state_d = COLLECT;
        count_d = 3'd0;
      end
    endcase

    if (key_valid || (count_q == 3'd0) || (state_q != COLLECT) || timeoutHit)
      timer_d = 24'd0;
    else
      timer_d = timer_q + 24'd1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= COLLECT;
      count_q <= 3'd0;
      timer_q <= 24'd0;
      for (int i = 0; i < 6; i++) slot_q[i] <= 4'd0;
      inA_q   <= 4'd0;
      inB_q   <= 4'd0;
      stage_q <= 2'b00;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      for (int i = 0; i < 6; i++) slot_q[i] <= slot_d[i];
      inA_q   <= inA_d;
      inB_q   <= inB_d;
      stage_q <= stage_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign inA         = inA_q;
  assign inB         = inB_q;
  assign a0          = stage_q[0];
  assign a1          = stage_q[1];
  assign load_stb    = load_q;
  assign digit_count = count_q;
  assign busy        = busy_q;
  assign entry_err   = err_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Directed self-checking bench for keypad_entry_sequencer (short timeout build).
module tb_keypad_entry_sequencer;

  logic       clk;
  logic       clr_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] inA;
  logic [3:0] inB;
  logic       a0;
  logic       a1;
  logic       load_stb;
  logic [2:0] digit_count;
  logic       busy;
  logic       entry_err;
  logic       timeout;

  int compareCount  = 0;
  int mismatchCount = 0;

  keypad_entry_sequencer #(.TIMEOUT_CYCLES(24'd8)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .inA         (inA),
    .inB         (inB),
    .a0          (a0),
    .a1          (a1),
    .load_stb    (load_stb),
    .digit_count (digit_count),
    .busy        (busy),
    .entry_err   (entry_err),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: presents one key for the next rising edge and
  // returns at the following falling edge, where that edge's results are visible.
  task automatic applyStimulus(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Checks one strobe cycle of an emit sequence, then advances a cycle.
  task automatic checkStrobe(input string tag, input logic [1:0] stage,
                             input logic [3:0] expA, input logic [3:0] expB);
    checkOutput({tag, "_stb"},   {7'd0, load_stb}, 8'd1);
    checkOutput({tag, "_busy"},  {7'd0, busy}, 8'd1);
    checkOutput({tag, "_stage"}, {6'd0, a1, a0}, {6'd0, stage});
    checkOutput({tag, "_inA"},   {4'd0, inA}, {4'd0, expA});
    checkOutput({tag, "_inB"},   {4'd0, inB}, {4'd0, expB});
    @(negedge clk);
  endtask

  initial begin
    clr_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    #12;
    checkOutput("rst_count", {5'd0, digit_count}, 8'd0);
    checkOutput("rst_stb",   {7'd0, load_stb}, 8'd0);
    checkOutput("rst_busy",  {7'd0, busy}, 8'd0);
    checkOutput("rst_stage", {6'd0, a1, a0}, 8'd0);
    checkOutput("rst_inAB",  {inA, inB}, 8'h00);
    checkOutput("rst_flags", {6'd0, entry_err, timeout}, 8'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    // First key after reset release is accepted; then clear without error.
    applyStimulus(4'd1);
    checkOutput("first_key_count", {5'd0, digit_count}, 8'd1);
    applyStimulus(4'hC);
    checkOutput("clear_count", {5'd0, digit_count}, 8'd0);
    checkOutput("clear_err", {7'd0, entry_err}, 8'd0);

    // Full entry 1..6 then enter.
    for (int i = 1; i <= 6; i++) applyStimulus(4'(i));
    checkOutput("six_count", {5'd0, digit_count}, 8'd6);
    applyStimulus(4'hB);
    checkStrobe("e1_s0", 2'b00, 4'd1, 4'd2);
    checkStrobe("e1_s1", 2'b01, 4'd3, 4'd4);
    checkStrobe("e1_s2", 2'b10, 4'd5, 4'd6);
    checkStrobe("e1_j",  2'b11, 4'd0, 4'd0);
    checkOutput("e1_after_stb",   {7'd0, load_stb}, 8'd0);
    checkOutput("e1_after_busy",  {7'd0, busy}, 8'd0);
    checkOutput("e1_after_count", {5'd0, digit_count}, 8'd0);
    checkOutput("e1_hold_stage",  {6'd0, a1, a0}, 8'd3);

    // Short entry: enter rejected.
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'hB);
    checkOutput("short_err",   {7'd0, entry_err}, 8'd1);
    checkOutput("short_stb",   {7'd0, load_stb}, 8'd0);
    checkOutput("short_count", {5'd0, digit_count}, 8'd3);
    @(negedge clk);
    checkOutput("short_err_pulse", {7'd0, entry_err}, 8'd0);
    checkOutput("short_no_stb", {7'd0, load_stb}, 8'd0);
    applyStimulus(4'hC);

    // Seventh digit rejected, backspace, replace last digit.
    for (int i = 1; i <= 6; i++) applyStimulus(4'(i));
    applyStimulus(4'd7);
    checkOutput("overflow_err",   {7'd0, entry_err}, 8'd1);
    checkOutput("overflow_count", {5'd0, digit_count}, 8'd6);
    applyStimulus(4'hA);
    checkOutput("back_count", {5'd0, digit_count}, 8'd5);
    checkOutput("back_err",   {7'd0, entry_err}, 8'd0);
    applyStimulus(4'd9);
    applyStimulus(4'hB);
    checkStrobe("e2_s0", 2'b00, 4'd1, 4'd2);
    checkStrobe("e2_s1", 2'b01, 4'd3, 4'd4);
    checkStrobe("e2_s2", 2'b10, 4'd5, 4'd9);
    checkStrobe("e2_j",  2'b11, 4'd0, 4'd0);

    // Backspace on an empty buffer.
    applyStimulus(4'hA);
    checkOutput("empty_back_err",   {7'd0, entry_err}, 8'd1);
    checkOutput("empty_back_count", {5'd0, digit_count}, 8'd0);

    // Idle timeout with TIMEOUT_CYCLES = 8.
    applyStimulus(4'd5);
    repeat (7) @(negedge clk);
    checkOutput("to_early",       {7'd0, timeout}, 8'd0);
    checkOutput("to_early_count", {5'd0, digit_count}, 8'd1);
    @(negedge clk);
    checkOutput("to_fire",       {7'd0, timeout}, 8'd1);
    checkOutput("to_fire_count", {5'd0, digit_count}, 8'd0);
    @(negedge clk);
    checkOutput("to_pulse", {7'd0, timeout}, 8'd0);

    // Reserved key on the would-be timeout edge suppresses the timeout.
    applyStimulus(4'd5);
    repeat (7) @(negedge clk);
    applyStimulus(4'hF);
    checkOutput("to_blocked",       {7'd0, timeout}, 8'd0);
    checkOutput("to_blocked_count", {5'd0, digit_count}, 8'd1);
    checkOutput("reserved_err",     {7'd0, entry_err}, 8'd0);
    applyStimulus(4'hC);

    // Reset asserted mid-emit.
    for (int i = 1; i <= 6; i++) applyStimulus(4'(i));
    applyStimulus(4'hB);
    @(negedge clk);
    checkOutput("mid_in_emit1", {7'd0, load_stb}, 8'd1);
    #2 clr_n = 1'b0;
    #1;
    checkOutput("mid_rst_stb",   {7'd0, load_stb}, 8'd0);
    checkOutput("mid_rst_busy",  {7'd0, busy}, 8'd0);
    checkOutput("mid_rst_stage", {6'd0, a1, a0}, 8'd0);
    checkOutput("mid_rst_inAB",  {inA, inB}, 8'h00);
    checkOutput("mid_rst_count", {5'd0, digit_count}, 8'd0);
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_stb", {7'd0, load_stb}, 8'd0);
    end
    applyStimulus(4'hE);
    checkOutput("post_rst_reserved_count", {5'd0, digit_count}, 8'd0);
    checkOutput("post_rst_reserved_err",   {7'd0, entry_err}, 8'd0);
    applyStimulus(4'hB);
    checkOutput("post_rst_enter_err", {7'd0, entry_err}, 8'd1);
    checkOutput("post_rst_enter_stb", {7'd0, load_stb}, 8'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
